// File: rtl/slime_pkg.sv
// Shared slime/court types and constants for the player controllers and the ball block.
package slime_pkg;

   localparam int unsigned SLIME_W        = 10;
   localparam int unsigned SLIME_VW       = 8;
   localparam int unsigned COURT_Y_GROUND = 479;
   localparam int unsigned COURT_X_HI     = 639;
   localparam int unsigned COURT_X_MID    = 320;

   typedef enum logic {GROUND, AIR} slime_state_t;

   typedef logic signed [SLIME_VW-1:0] vel_t;

endpackage

// File: rtl/slime_axis_clamp.sv
// Combinational saturating add-and-clamp: result = clamp(value + delta, lo, hi).
module slime_axis_clamp #(
   parameter int unsigned W = 10
) (
   input  logic [W-1:0]        i_value,
   input  logic signed [W+1:0] i_delta,
   input  logic [W-1:0]        i_lo,
   input  logic [W-1:0]        i_hi,
   output logic [W-1:0]        o_result_c
);

   logic signed [W+1:0] w_sum;

   // Two guard bits keep the sum from wrapping for any in-range value/delta pair.
   assign w_sum = $signed({2'b00, i_value}) + i_delta;

   always_comb begin
      o_result_c = w_sum[W-1:0];
      if (w_sum < $signed({2'b00, i_lo})) begin
         o_result_c = i_lo;
      end else if (w_sum > $signed({2'b00, i_hi})) begin
         o_result_c = i_hi;
      end
   end

endmodule

// File: rtl/slime_player_ctrl.sv
// Per-player slime physics: walking, three-level jumps, gravity, floor landing,
// ceiling clamp and half-court wall clamping, updated once per video frame.
module slime_player_ctrl
   import slime_pkg::*;
#(
   parameter int unsigned W        = SLIME_W,
   parameter int unsigned VW       = SLIME_VW,
   parameter int unsigned X_INIT   = 400,
   parameter int unsigned X_LO     = 0,
   parameter int unsigned X_HI     = COURT_X_HI,
   parameter int unsigned Y_GROUND = COURT_Y_GROUND,
   parameter int unsigned Y_TOP    = 0,
   parameter int unsigned SIZE     = 50,
   parameter int unsigned X_STEP   = 5,
   parameter int unsigned GRAVITY  = 1,
   parameter int unsigned VY_MAX   = 15,
   parameter int unsigned JUMP_HI  = 15,
   parameter int unsigned JUMP_MED = 12,
   parameter int unsigned JUMP_LO  = 10
) (
   input  logic                 frame_clk,
   input  logic                 Reset,
   input  logic                 en,
   input  logic                 key_left,
   input  logic                 key_right,
   input  logic [2:0]           key_jump,
   output logic [W-1:0]         pos_x,
   output logic [W-1:0]         pos_y,
   output logic [W-1:0]         size,
   output logic signed [VW-1:0] vel_y,
   output logic                 airborne,
   output logic                 landed
);

   localparam int unsigned NYW = VW + W + 1;

   slime_state_t        r_state,    w_state_nxt;
   logic [W-1:0]        r_pos_x,    w_pos_x_nxt;
   logic [W-1:0]        r_pos_y,    w_pos_y_nxt;
   logic signed [VW-1:0] r_vel_y,   w_vel_y_nxt;
   logic                r_armed,    w_armed_nxt;
   logic                r_airborne, w_airborne_nxt;
   logic                r_landed,   w_landed_nxt;

   logic signed [W+1:0]  w_dx;
   logic [W-1:0]         w_x_clamped;
   logic [W-1:0]         w_y_clamped;
   logic signed [NYW-1:0] w_ny;
   logic                 w_land;
   logic                 w_ceil;
   logic signed [VW:0]   w_vy_inc;
   logic signed [VW-1:0] w_vy_grav;
   logic signed [VW-1:0] w_jump_vel;

   always_comb begin
      w_dx = '0;
      if (key_right && !key_left) begin
         w_dx = $signed((W+2)'(X_STEP));
      end else if (key_left && !key_right) begin
         w_dx = -$signed((W+2)'(X_STEP));
      end
   end

   slime_axis_clamp #(.W(W)) u_x_clamp (
      .i_value    (r_pos_x),
      .i_delta    (w_dx),
      .i_lo       (W'(X_LO + SIZE)),
      .i_hi       (W'(X_HI - SIZE)),
      .o_result_c (w_x_clamped)
   );

   // Vertical step bounded between the ceiling (offset by the radius) and the floor.
   slime_axis_clamp #(.W(W)) u_y_clamp (
      .i_value    (r_pos_y),
      .i_delta    ((W+2)'(r_vel_y)),
      .i_lo       (W'(Y_TOP + SIZE)),
      .i_hi       (W'(Y_GROUND)),
      .o_result_c (w_y_clamped)
   );

   assign w_ny     = $signed(NYW'(r_pos_y)) + NYW'(r_vel_y);
   assign w_land   = w_ny >= $signed(NYW'(Y_GROUND));
   assign w_ceil   = (w_ny - $signed(NYW'(SIZE))) <= $signed(NYW'(Y_TOP));
   assign w_vy_inc = $signed({r_vel_y[VW-1], r_vel_y}) + $signed((VW+1)'(GRAVITY));
   assign w_vy_grav = (w_vy_inc > $signed((VW+1)'(VY_MAX))) ? $signed(VW'(VY_MAX))
                                                           : w_vy_inc[VW-1:0];

   always_comb begin
      if (key_jump[2]) begin
         w_jump_vel = -$signed(VW'(JUMP_HI));
      end else if (key_jump[1]) begin
         w_jump_vel = -$signed(VW'(JUMP_MED));
      end else begin
         w_jump_vel = -$signed(VW'(JUMP_LO));
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pos_x_nxt    = r_pos_x;
      w_pos_y_nxt    = r_pos_y;
      w_vel_y_nxt    = r_vel_y;
      w_armed_nxt    = r_armed;
      w_airborne_nxt = r_airborne;
      w_landed_nxt   = 1'b0;
      if (en) begin
         w_pos_x_nxt = w_x_clamped;
         if (key_jump == 3'b000) begin
            w_armed_nxt = 1'b1;
         end
         case (r_state)
            GROUND: begin
               if (r_armed && (key_jump != 3'b000)) begin
                  w_vel_y_nxt = w_jump_vel;
                  w_state_nxt = AIR;
                  w_armed_nxt = 1'b0;
               end
            end
            AIR: begin
               w_pos_y_nxt = w_y_clamped;
               if (w_land) begin
                  w_vel_y_nxt  = '0;
                  w_state_nxt  = GROUND;
                  w_landed_nxt = 1'b1;
               end else if (w_ceil) begin
                  w_vel_y_nxt = '0;
               end else begin
                  w_vel_y_nxt = w_vy_grav;
               end
            end
            default: w_state_nxt = GROUND;
         endcase
         w_airborne_nxt = (w_state_nxt == AIR);
      end
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         r_state    <= GROUND;
         r_pos_x    <= W'(X_INIT);
         r_pos_y    <= W'(Y_GROUND);
         r_vel_y    <= '0;
         r_armed    <= 1'b1;
         r_airborne <= 1'b0;
         r_landed   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pos_x    <= w_pos_x_nxt;
         r_pos_y    <= w_pos_y_nxt;
         r_vel_y    <= w_vel_y_nxt;
         r_armed    <= w_armed_nxt;
         r_airborne <= w_airborne_nxt;
         r_landed   <= w_landed_nxt;
      end
   end

   assign pos_x    = r_pos_x;
   assign pos_y    = r_pos_y;
   assign size     = W'(SIZE);
   assign vel_y    = r_vel_y;
   assign airborne = r_airborne;
   assign landed   = r_landed;

endmodule
